// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: arbiter states and read-data owner.
package memory_arbiter_pkg;

    // Owner of the last granted cycle
    typedef enum logic [1:0] {
        ARB_IDLE       = 2'd0,
        ARB_CPU        = 2'd1,
        ARB_DEV        = 2'd2,
        ARB_DEV_LOCKED = 2'd3
    } arb_state_e;

    // Which master the read data returning this cycle belongs to
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DEV  = 2'd2
    } owner_e;

    // Bits needed to hold a count from 0 up to and including limit
    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arbiter_starve_counter.sv
// Saturating count of consecutive cpu grants while the device is waiting.
module arbiter_starve_counter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic clear_i,
    output logic at_limit_o
);

    localparam int unsigned CW = starve_cnt_width(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear wins; otherwise count up and stick at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: cpu priority, bounded device starvation, device lock.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 13,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                     clock_input,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_write,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0]    cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,
    output logic [DATA_WIDTH-1:0]    cpu_rdata,
    input  logic                     dev_req,
    input  logic                     dev_write,
    input  logic [ADDRESS_WIDTH-1:0] dev_addr,
    input  logic [DATA_WIDTH-1:0]    dev_wdata,
    input  logic                     dev_lock,
    output logic                     dev_gnt,
    output logic                     dev_rvalid,
    output logic [DATA_WIDTH-1:0]    dev_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    owner_e     rd_owner_q;
    owner_e     rd_owner_d;
    logic       locked_hold;
    logic       at_limit;

    arbiter_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i      (clock_input),
        .rst_i      (reset),
        .inc_i      (cpu_gnt & dev_req),
        .clear_i    (dev_gnt | ~dev_req),
        .at_limit_o (at_limit)
    );

    // Grant decision; grants are masked while reset is high so every output reads 0
    always_comb begin
        cpu_gnt     = 1'b0;
        dev_gnt     = 1'b0;
        locked_hold = (state_q == ARB_DEV_LOCKED) && dev_lock;
        if (reset) begin
            cpu_gnt = 1'b0;
            dev_gnt = 1'b0;
        end else if (locked_hold) begin
            dev_gnt = dev_req;
        end else if (cpu_req && dev_req) begin
            if (at_limit) begin
                dev_gnt = 1'b1;
            end else begin
                cpu_gnt = 1'b1;
            end
        end else begin
            cpu_gnt = cpu_req;
            dev_gnt = dev_req;
        end
    end

    // RAM port mux from the granted master, all zero when nobody is granted
    always_comb begin
        mem_en    = cpu_gnt | dev_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_write;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dev_gnt) begin
            mem_we    = dev_write;
            mem_addr  = dev_addr;
            mem_wdata = dev_wdata;
        end
    end

    // Next owner state and which master the next cycle's read data belongs to
    always_comb begin
        state_d    = ARB_IDLE;
        rd_owner_d = OWNER_NONE;
        if ((dev_gnt && dev_lock) || locked_hold) begin
            state_d = ARB_DEV_LOCKED;
        end else if (dev_gnt) begin
            state_d = ARB_DEV;
        end else if (cpu_gnt) begin
            state_d = ARB_CPU;
        end
        if (cpu_gnt && !cpu_write) begin
            rd_owner_d = OWNER_CPU;
        end else if (dev_gnt && !dev_write) begin
            rd_owner_d = OWNER_DEV;
        end
    end

    // Arbiter state and read owner registers
    always_ff @(posedge clock_input or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            rd_owner_q <= OWNER_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign cpu_rvalid = (rd_owner_q == OWNER_CPU);
    assign dev_rvalid = (rd_owner_q == OWNER_DEV);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dev_rdata  = dev_rvalid ? mem_rdata : '0;

endmodule
